// File: rtl/proto_defs_pkg.sv
// ============================================================================
//  Module   : proto_defs (package)
//  Purpose  : Host-protocol constants and transmit-framer state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package proto_defs;

    localparam logic [7:0]  SYNC_BYTE    = 8'h7e;
    localparam int          MESSAGE_MIN  = 5;
    localparam int          MESSAGE_MAX  = 64;
    localparam logic [3:0]  MESSAGE_DEST = 4'h1;
    localparam logic [15:0] CRC_INIT     = 16'hffff;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        SEQ     = 3'd2,
        PAYLOAD = 3'd3,
        CRC_HI  = 3'd4,
        CRC_LO  = 3'd5,
        SYNC    = 3'd6,
        DRAIN   = 3'd7
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/crc16_ccitt_step.sv
// ============================================================================
//  Module   : crc16_ccitt_step
//  Purpose  : One-byte update of the host-compatible CCITT CRC (combinational).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc16_ccitt_step (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [7:0] w_x0;
    logic [7:0] w_x;

    assign w_x0    = data ^ crc_in[7:0];
    assign w_x     = w_x0 ^ (w_x0 << 4);
    assign crc_out = ({w_x, 8'h00} | {8'h00, crc_in[15:8]})
                   ^ {8'h00, (w_x >> 4)}
                   ^ ({8'h00, w_x} << 3);

endmodule

`default_nettype wire

// File: rtl/msg_frame_tx.sv
// ============================================================================
//  Module   : msg_frame_tx
//  Purpose  : Wraps queued responses (and pending acks) into
//             [len][seq][payload][crc_hi][crc_lo][sync] blocks on a byte link.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_frame_tx #(
    parameter int         LEN_BITS    = 8,
    parameter int         MAX_PAYLOAD = 59,
    parameter logic [7:0] SYNC_BYTE   = proto_defs::SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LEN_BITS-1:0] len_fifo_data,
    input  logic                len_fifo_empty,
    output logic                len_fifo_rd_en,
    input  logic [7:0]          ring_data,
    input  logic                ring_empty,
    output logic                ring_rd_en,
    input  logic [3:0]          rx_seq,
    input  logic                ack_req,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                err_oversize
);

    import proto_defs::*;

    tx_state_t           r_state;
    tx_state_t           w_next;
    logic [15:0]         r_crc;
    logic [15:0]         w_crc_next;
    logic [LEN_BITS-1:0] r_count;
    logic [3:0]          r_seq;
    logic                r_ack_pending;
    logic                r_err;
    logic                r_len_pop;

    logic                w_oversize;
    logic                w_pop_len;
    logic                w_pop_ring;
    logic                w_start;
    logic                w_crc_en;
    logic [7:0]          w_blk_len;

    // A length whose block byte would not fit in 8 bits is also oversize.
    assign w_oversize = (32'(len_fifo_data) > 32'(MAX_PAYLOAD))
                     || (32'(len_fifo_data) > 32'(255 - MESSAGE_MIN));
    assign w_blk_len  = 8'(r_count) + 8'(MESSAGE_MIN);

    crc16_ccitt_step u_crc (
        .crc_in  (r_crc),
        .data    (tx_data),
        .crc_out (w_crc_next)
    );

    always_comb begin
        w_next     = r_state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        w_pop_len  = 1'b0;
        w_pop_ring = 1'b0;
        w_start    = 1'b0;
        w_crc_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!len_fifo_empty) begin
                    w_pop_len = 1'b1;
                    if (w_oversize) begin
                        w_next = DRAIN;
                    end else begin
                        w_next  = LEN;
                        w_start = 1'b1;
                    end
                end else if (r_ack_pending) begin
                    w_next  = LEN;
                    w_start = 1'b1;
                end
            end
            LEN: begin
                tx_valid = 1'b1;
                tx_data  = w_blk_len;
                if (tx_ready) begin
                    w_crc_en = 1'b1;
                    w_next   = SEQ;
                end
            end
            SEQ: begin
                tx_valid = 1'b1;
                tx_data  = {MESSAGE_DEST, r_seq};
                if (tx_ready) begin
                    w_crc_en = 1'b1;
                    w_next   = (r_count == '0) ? CRC_HI : PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_valid = !ring_empty;
                tx_data  = ring_data;
                if (!ring_empty && tx_ready) begin
                    w_pop_ring = 1'b1;
                    w_crc_en   = 1'b1;
                    if (r_count == LEN_BITS'(1)) begin
                        w_next = CRC_HI;
                    end
                end
            end
            CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = r_crc[15:8];
                if (tx_ready) begin
                    w_next = CRC_LO;
                end
            end
            CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = r_crc[7:0];
                if (tx_ready) begin
                    w_next = SYNC;
                end
            end
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    w_next = IDLE;
                end
            end
            DRAIN: begin
                if (!ring_empty) begin
                    w_pop_ring = 1'b1;
                    if (r_count == LEN_BITS'(1)) begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_crc         <= CRC_INIT;
            r_count       <= '0;
            r_seq         <= 4'h0;
            r_ack_pending <= 1'b0;
            r_err         <= 1'b0;
            r_len_pop     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_len_pop <= w_pop_len;
            if (w_start) begin
                r_crc <= CRC_INIT;
                r_seq <= rx_seq;
            end else if (w_crc_en) begin
                r_crc <= w_crc_next;
            end
            if (w_pop_len) begin
                r_count <= len_fifo_data;
            end else if (w_start) begin
                r_count <= '0;
            end else if (w_pop_ring) begin
                r_count <= r_count - {{(LEN_BITS-1){1'b0}}, 1'b1};
            end
            // A fresh ack_req landing on a frame start must survive it.
            r_ack_pending <= ack_req | (r_ack_pending & !w_start);
            if (w_pop_len && w_oversize) begin
                r_err <= 1'b1;
            end
        end
    end

    // Pops are masked during reset so an aborted frame leaves the sources intact.
    assign len_fifo_rd_en = r_len_pop & !rst;
    assign ring_rd_en     = w_pop_ring & !rst;
    assign busy           = (r_state != IDLE);
    assign err_oversize   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_msg_frame_tx.sv
// ============================================================================
//  Module   : tb_msg_frame_tx
//  Purpose  : Scoreboard bench for msg_frame_tx with a byte-list frame model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msg_frame_tx;

    typedef logic [7:0] byte_q_t [$];

    logic       clk;
    logic       rst;
    logic [7:0] len_fifo_data;
    logic       len_fifo_empty;
    logic       len_fifo_rd_en;
    logic [7:0] ring_data;
    logic       ring_empty;
    logic       ring_rd_en;
    logic [3:0] rx_seq;
    logic       ack_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err_oversize;

    byte_q_t    len_q;
    byte_q_t    ring_q;
    byte_q_t    exp_q;
    byte_q_t    empty_q;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         len_pops = 0;
    int         ring_pops = 0;
    bit         rand_ready = 0;
    bit         pl_cap, pr_cap, prev_pl;
    bit         stall_prev = 0;
    logic [7:0] stall_data;

    msg_frame_tx dut (
        .clk            (clk),
        .rst            (rst),
        .len_fifo_data  (len_fifo_data),
        .len_fifo_empty (len_fifo_empty),
        .len_fifo_rd_en (len_fifo_rd_en),
        .ring_data      (ring_data),
        .ring_empty     (ring_empty),
        .ring_rd_en     (ring_rd_en),
        .rx_seq         (rx_seq),
        .ack_req        (ack_req),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .err_oversize   (err_oversize)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reflected CRC-16, polynomial 0x8408, init 0xffff, bit-serial form.
    function automatic logic [15:0] ref_crc(input byte_q_t b);
        logic [15:0] c;
        c = 16'hffff;
        foreach (b[i]) begin
            c = c ^ {8'h00, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic expect_frame(input logic [3:0] seq, input byte_q_t pl);
        byte_q_t     blk;
        logic [15:0] c;
        blk.push_back(8'(pl.size() + 5));
        blk.push_back({4'h1, seq});
        foreach (pl[i]) blk.push_back(pl[i]);
        c = ref_crc(blk);
        foreach (blk[i]) exp_q.push_back(blk[i]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(8'h7e);
    endtask

    task automatic refresh();
        len_fifo_empty = (len_q.size() == 0);
        len_fifo_data  = len_fifo_empty ? 8'h00 : len_q[0];
        ring_empty     = (ring_q.size() == 0);
        ring_data      = ring_empty ? 8'h00 : ring_q[0];
    endtask

    // Source model: show-ahead FIFO and ring, popped on the clock edge.
    always begin
        @(negedge clk);
        #2;
        pl_cap = len_fifo_rd_en;
        pr_cap = ring_rd_en;
        if (pl_cap) begin
            chk("len_pop_nonempty", len_fifo_empty, 0);
            chk("len_pop_single", prev_pl, 0);
        end
        if (pr_cap) chk("ring_pop_nonempty", ring_empty, 0);
        prev_pl = pl_cap;
        @(posedge clk);
        #1;
        if (pl_cap && len_q.size() != 0) begin
            void'(len_q.pop_front());
            len_pops++;
        end
        if (pr_cap && ring_q.size() != 0) begin
            void'(ring_q.pop_front());
            ring_pops++;
        end
        refresh();
    end

    always @(negedge clk) tx_ready = rand_ready ? 1'($urandom) : 1'b1;

    // Monitor: every accepted byte is checked against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, stall_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_byte: got %02h, expected no transfer", tx_data);
                end else begin
                    chk("tx_byte", tx_data, exp_q.pop_front());
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic wait_done();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("frame_done", (exp_q.size() == 0) && !busy, 1);
    endtask

    task automatic send(input logic [3:0] seq, input byte_q_t pl, input bit push_ring);
        @(negedge clk);
        rx_seq    = seq;
        len_pops  = 0;
        ring_pops = 0;
        expect_frame(seq, pl);
        if (push_ring) foreach (pl[i]) ring_q.push_back(pl[i]);
        len_q.push_back(8'(pl.size()));
        refresh();
        wait_done();
        chk("len_pops", len_pops, 1);
        chk("ring_pops", ring_pops, pl.size());
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_len_rd"}, len_fifo_rd_en, 0);
        chk({tag, "_ring_rd"}, ring_rd_en, 0);
        chk({tag, "_err"}, err_oversize, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t pl;
        rst = 1'b1; ack_req = 1'b0; rx_seq = 4'h0;
        refresh();
        repeat (3) @(negedge clk);
        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Ack-only block
        rx_seq = 4'h3;
        len_pops = 0; ring_pops = 0;
        expect_frame(4'h3, empty_q);
        ack_req = 1'b1;
        @(negedge clk);
        ack_req = 1'b0;
        wait_done();
        chk("ack_len_pops", len_pops, 0);
        chk("ack_ring_pops", ring_pops, 0);
        repeat (10) @(negedge clk);
        #3;
        chk("ack_cleared_idle", busy, 0);

        // Plain payload, then the same under random back-pressure
        pl = '{8'h00, 8'h2a, 8'h81};
        send(4'h0, pl, 1);
        rand_ready = 1;
        send(4'h0, pl, 1);
        rand_ready = 0;

        // Ring starvation mid-payload
        @(negedge clk);
        rx_seq = 4'h7; len_pops = 0; ring_pops = 0;
        pl = '{8'hc3, 8'h19, 8'h5e, 8'hf0};
        expect_frame(4'h7, pl);
        ring_q.push_back(pl[0]); ring_q.push_back(pl[1]);
        len_q.push_back(8'd4);
        refresh();
        for (int k = 0; k < 200 && ring_pops < 2; k++) @(negedge clk);
        chk("starve_prefill", ring_pops, 2);
        repeat (20) begin
            #3;
            chk("starve_valid", tx_valid, 0);
            chk("starve_ring_rd", ring_rd_en, 0);
            @(negedge clk);
        end
        ring_q.push_back(pl[2]); ring_q.push_back(pl[3]);
        refresh();
        wait_done();
        chk("starve_ring_pops", ring_pops, 4);

        // Oversize length queued together with an ack request
        @(negedge clk);
        rx_seq = 4'h5; len_pops = 0; ring_pops = 0;
        expect_frame(4'h5, empty_q);
        for (int i = 0; i < 60; i++) ring_q.push_back(8'($urandom));
        len_q.push_back(8'd60);
        ack_req = 1'b1;
        refresh();
        @(negedge clk);
        ack_req = 1'b0;
        wait_done();
        chk("oversize_err", err_oversize, 1);
        chk("oversize_ring_pops", ring_pops, 60);
        chk("oversize_len_pops", len_pops, 1);

        // Random frames including the 0 and MAX_PAYLOAD boundaries
        for (int f = 0; f < 10; f++) begin
            int n;
            n = (f == 0) ? 0 : (f == 1) ? 59 : int'($urandom_range(0, 59));
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            rand_ready = f[0];
            send(4'($urandom), pl, 1);
        end
        rand_ready = 0;

        // Reset in the middle of the payload
        @(negedge clk);
        rx_seq = 4'h2; len_pops = 0; ring_pops = 0;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        expect_frame(4'h2, pl);
        foreach (pl[i]) ring_q.push_back(pl[i]);
        len_q.push_back(8'd5);
        refresh();
        for (int k = 0; k < 200 && ring_pops < 2; k++) @(negedge clk);
        chk("abort_prefill", ring_pops, 2);
        rst = 1'b1;
        @(negedge clk);
        #3;
        check_idle_outputs("abort");
        chk("abort_ring_left", ring_q.size(), 3);
        exp_q.delete();
        rst = 1'b0;
        pl = '{ring_q[0]};
        send(4'h2, pl, 0);
        ring_q.delete();
        refresh();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
